// File: rtl/hdc_mem_arbiter_if.sv
// Requester and RAM-side bus of the hypervector memory arbiter.
// Latency: none (wires only).
// Backpressure: per-requester valid/ready on read and write; read data tagged by rsp_valid.
interface hdc_mem_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 21,
    parameter int DATA_W = 32
);
    // read request side
    logic [N_REQ-1:0]        rd_valid;
    logic [N_REQ*ADDR_W-1:0] rd_addr;
    logic [N_REQ-1:0]        rd_lock;
    logic [N_REQ-1:0]        rd_ready;
    logic [N_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]       rsp_data;
    // write request side
    logic [N_REQ-1:0]        wr_valid;
    logic [N_REQ*ADDR_W-1:0] wr_addr;
    logic [N_REQ*DATA_W-1:0] wr_data;
    logic [N_REQ-1:0]        wr_lock;
    logic [N_REQ-1:0]        wr_ready;
    // RAM side
    logic                    ram_we_n;
    logic [ADDR_W-1:0]       ram_waddress;
    logic [DATA_W-1:0]       ram_data_i;
    logic [ADDR_W-1:0]       ram_raddress;
    logic [DATA_W-1:0]       ram_data_o;

    // arbiter view
    modport slave (
        input  rd_valid, rd_addr, rd_lock,
        output rd_ready, rsp_valid, rsp_data,
        input  wr_valid, wr_addr, wr_data, wr_lock,
        output wr_ready,
        output ram_we_n, ram_waddress, ram_data_i, ram_raddress,
        input  ram_data_o
    );

    // requester / RAM environment view
    modport master (
        output rd_valid, rd_addr, rd_lock,
        input  rd_ready, rsp_valid, rsp_data,
        output wr_valid, wr_addr, wr_data, wr_lock,
        input  wr_ready,
        input  ram_we_n, ram_waddress, ram_data_i, ram_raddress,
        output ram_data_o
    );
endinterface

// File: rtl/hdc_mem_arbiter.sv
// Shares one 1W/1R RAM between N_REQ hypervector engines with independent round-robin+lock arbiters.
// Latency: grant/ready combinational; read response 1 cycle after the read handshake.
// Backpressure: losers see ready low and must hold valid; a lock pins the grant to its owner.

// Round-robin arbiter with grant lock, used for both RAM ports.
module hdc_mem_arbiter_rr #(
    parameter int N_REQ = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N_REQ-1:0]     valid,
    input  logic [N_REQ-1:0]     lock,
    output logic [N_REQ-1:0]     ready,
    output logic                 gnt_vld,
    output logic [$clog2(N_REQ)-1:0] gnt_idx
);
    localparam int IDX_W = $clog2(N_REQ);

    typedef enum logic {ARB, LOCKED} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   lock_owner_q, lock_owner_d;
    logic [IDX_W-1:0]   cand;
    logic               hold;
    logic               found;

    // Grant selection and next arbiter state; ready is forced low while in reset.
    always_comb begin
        hold         = (state_q == LOCKED) && lock[lock_owner_q];
        found        = 1'b0;
        gnt_idx      = '0;
        cand         = '0;
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        lock_owner_d = lock_owner_q;

        if (hold) begin
            found   = valid[lock_owner_q];
            gnt_idx = lock_owner_q;
        end else begin
            // walk from farthest to nearest so the nearest valid one from rr_ptr wins
            for (int k = N_REQ - 1; k >= 0; k--) begin
                cand = IDX_W'((int'(rr_ptr_q) + k) % N_REQ);
                if (valid[cand]) begin
                    found   = 1'b1;
                    gnt_idx = cand;
                end
            end
        end

        gnt_vld = found && reset_n;
        ready   = '0;
        if (gnt_vld) begin
            ready[gnt_idx] = 1'b1;
        end

        // a released lock falls straight back into normal arbitration this cycle
        if (!hold) begin
            state_d = ARB;
            if (gnt_vld) begin
                rr_ptr_d = IDX_W'((int'(gnt_idx) + 1) % N_REQ);
                if (lock[gnt_idx]) begin
                    state_d      = LOCKED;
                    lock_owner_d = gnt_idx;
                end
            end
        end
    end

    // Arbiter state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ARB;
            rr_ptr_q     <= '0;
            lock_owner_q <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            lock_owner_q <= lock_owner_d;
        end
    end
endmodule

module hdc_mem_arbiter #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 21,
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    hdc_mem_arbiter_if.slave   bus
);
    localparam int IDX_W = $clog2(N_REQ);

    logic [N_REQ-1:0]  rd_rdy, wr_rdy;
    logic              rd_gnt_vld, wr_gnt_vld;
    logic [IDX_W-1:0]  rd_gnt_idx, wr_gnt_idx;

    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;

    hdc_mem_arbiter_rr #(.N_REQ(N_REQ)) u_rd_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .valid   (bus.rd_valid),
        .lock    (bus.rd_lock),
        .ready   (rd_rdy),
        .gnt_vld (rd_gnt_vld),
        .gnt_idx (rd_gnt_idx)
    );

    hdc_mem_arbiter_rr #(.N_REQ(N_REQ)) u_wr_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .valid   (bus.wr_valid),
        .lock    (bus.wr_lock),
        .ready   (wr_rdy),
        .gnt_vld (wr_gnt_vld),
        .gnt_idx (wr_gnt_idx)
    );

    // RAM address/data mux: follow the granted requester, otherwise hold the last grant.
    always_comb begin
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        raddr_d     = raddr_q;
        rsp_valid_d = rd_rdy;
        if (wr_gnt_vld) begin
            waddr_d = bus.wr_addr[int'(wr_gnt_idx)*ADDR_W +: ADDR_W];
            wdata_d = bus.wr_data[int'(wr_gnt_idx)*DATA_W +: DATA_W];
        end
        if (rd_gnt_vld) begin
            raddr_d = bus.rd_addr[int'(rd_gnt_idx)*ADDR_W +: ADDR_W];
        end
    end

    // Held RAM addresses/data and the response tag that tracks the RAM's 1-cycle read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            waddr_q     <= '0;
            wdata_q     <= '0;
            raddr_q     <= '0;
            rsp_valid_q <= '0;
        end else begin
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            raddr_q     <= raddr_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign bus.rd_ready     = rd_rdy;
    assign bus.wr_ready     = wr_rdy;
    assign bus.ram_we_n     = ~wr_gnt_vld;
    assign bus.ram_waddress = waddr_d;
    assign bus.ram_data_i   = wdata_d;
    assign bus.ram_raddress = raddr_d;
    assign bus.rsp_valid    = rsp_valid_q;
    // no forwarding: same-cycle write/read of one address yields the RAM's old word
    assign bus.rsp_data     = bus.ram_data_o;
endmodule
